// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked two's-complement adder/subtractor.
// One CHUNK-bit slice is added per stage, carry registered between stages,
// valid/ready on both sides with a single whole-pipeline advance enable.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("pipelined_adder: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    // Per-stage pipeline registers (index k = output of stage k)
    logic             r_vld   [STAGES];
    logic             r_carry [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_ovf;

    // Stage inputs and combinational stage results
    logic             w_en;
    logic             w_vld_in   [STAGES];
    logic             w_carry_in [STAGES];
    logic [WIDTH-1:0] w_a_in     [STAGES];
    logic [WIDTH-1:0] w_b_in     [STAGES];
    logic [WIDTH-1:0] w_sum_in   [STAGES];
    logic [CHUNK:0]   w_chunk    [STAGES];
    logic [WIDTH-1:0] w_sum_nxt  [STAGES];
    logic             w_ovf_nxt;

    // Whole pipeline advances together whenever the output slot can move
    always_comb begin
        w_en = !r_vld[LAST] || out_ready;
    end

    // Stage input selection: stage 0 from the ports, later stages from the previous register
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_vld_in[k]   = 1'b0;
            w_carry_in[k] = 1'b0;
            w_a_in[k]     = '0;
            w_b_in[k]     = '0;
            w_sum_in[k]   = '0;
        end
        w_vld_in[0]   = in_valid;
        w_carry_in[0] = SUB ? 1'b1 : CIN;
        w_a_in[0]     = A;
        w_b_in[0]     = SUB ? ~B : B;
        w_sum_in[0]   = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_vld_in[k]   = r_vld[k-1];
            w_carry_in[k] = r_carry[k-1];
            w_a_in[k]     = r_a[k-1];
            w_b_in[k]     = r_b[k-1];
            w_sum_in[k]   = r_sum[k-1];
        end
    end

    // Slice add per stage, merging the new slice into the accumulated sum
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_chunk[k]   = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                         + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, w_carry_in[k]};
            w_sum_nxt[k] = w_sum_in[k];
            w_sum_nxt[k][k*CHUNK +: CHUNK] = w_chunk[k][CHUNK-1:0];
        end
        // Carry into the MSB is recovered as a^b^sum at that bit, so no extra adder split is needed
        w_ovf_nxt = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1]
                  ^ w_chunk[LAST][CHUNK-1] ^ w_chunk[LAST][CHUNK];
    end

    // Pipeline registers: async clear, capture only on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_vld[k]   <= 1'b0;
                r_carry[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_vld[k]   <= w_vld_in[k];
                r_carry[k] <= w_chunk[k][CHUNK];
                r_a[k]     <= w_a_in[k];
                r_b[k]     <= w_b_in[k];
                r_sum[k]   <= w_sum_nxt[k];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    // Output mapping from the last stage
    always_comb begin
        in_ready  = w_en;
        out_valid = r_vld[LAST];
        S         = r_sum[LAST];
        COUT      = r_carry[LAST];
        OVF       = r_ovf;
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4, STAGES=4).
module tb_pipelined_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        CIN;
    logic        SUB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        COUT;
    logic        OVF;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_deliv = 0;
    res_t sb[$];

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .CIN      (CIN),
        .SUB      (SUB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .COUT     (COUT),
        .OVF      (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        logic [15:0] bb;
        logic        c0;
        logic [16:0] t;
        res_t        r;
        bb  = sub ? ~b : b;
        c0  = sub ? 1'b1 : cin;
        t   = {1'b0, a} + {1'b0, bb} + {16'd0, c0};
        r.s = t[15:0];
        r.c = t[16];
        r.o = (a[15] == bb[15]) && (t[15] != a[15]);
        return r;
    endfunction

    // Scoreboard: sampled between edges; pop on delivery, push on accept
    always @(negedge clk) begin
        res_t e;
        #3;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_vec++;
                n_deliv++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got S=%h COUT=%b OVF=%b, none expected", S, COUT, OVF);
                end else begin
                    e = sb.pop_front();
                    if ({S, COUT, OVF} !== {e.s, e.c, e.o}) begin
                        n_err++;
                        $display("FAIL sb_result: got S=%h COUT=%b OVF=%b, want S=%h COUT=%b OVF=%b",
                                 S, COUT, OVF, e.s, e.c, e.o);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(A, B, CIN, SUB));
        end
    end

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        in_valid = v;
        A        = a;
        B        = b;
        CIN      = cin;
        SUB      = sub;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            #4;
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            out_ready = 1'($urandom);
            #3;
            n_vec++;
            if ({out_valid, S, COUT, OVF, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_state: got ov=%b S=%h C=%b O=%b ir=%b, want 0 0000 0 0 1",
                         out_valid, S, COUT, OVF, in_ready);
            end
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        rst_n     = 1'b1;
    endtask

    task automatic test_carry_ripple();
        logic [15:0] ta[2], tb[2], es[2];
        logic        tc[2], ec[2], eo[2];
        ta[0] = 16'hFFFF; tb[0] = 16'h0001; tc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1; eo[0] = 1'b0;
        ta[1] = 16'h7FFF; tb[1] = 16'h0000; tc[1] = 1'b1; es[1] = 16'h8000; ec[1] = 1'b0; eo[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            drive(1'b1, ta[t], tb[t], tc[t], 1'b0);
            #3;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL ripple_in_ready[%0d]: got %b want 1", t, in_ready);
            end
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
                #3;
                n_vec++;
                if (c < 4) begin
                    if (out_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL ripple_early[%0d] cyc %0d: out_valid=%b want 0", t, c, out_valid);
                    end
                end else if ({out_valid, S, COUT, OVF} !== {1'b1, es[t], ec[t], eo[t]}) begin
                    n_err++;
                    $display("FAIL ripple_result[%0d]: got ov=%b S=%h C=%b O=%b, want 1 %h %b %b",
                             t, out_valid, S, COUT, OVF, es[t], ec[t], eo[t]);
                end
            end
        end
    endtask

    task automatic test_subtract();
        logic [15:0] ta[2], tb[2], es[2];
        logic        ec[2], eo[2];
        ta[0] = 16'h8000; tb[0] = 16'h0001; es[0] = 16'h7FFF; ec[0] = 1'b1; eo[0] = 1'b1;
        ta[1] = 16'h0003; tb[1] = 16'h0005; es[1] = 16'hFFFE; ec[1] = 1'b0; eo[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            drive(1'b1, ta[t], tb[t], 1'b1, 1'b1);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
                #3;
                if (c == 4) begin
                    n_vec++;
                    if ({out_valid, S, COUT, OVF} !== {1'b1, es[t], ec[t], eo[t]}) begin
                        n_err++;
                        $display("FAIL sub_result[%0d]: got ov=%b S=%h C=%b O=%b, want 1 %h %b %b",
                                 t, out_valid, S, COUT, OVF, es[t], ec[t], eo[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_streaming();
        logic [9:0]  vin;
        logic [13:0] obs, exp_pat;
        bit          ok;
        vin     = 10'b11_1100_1111;  // bit i = in_valid in slot i; slots 4,5 are the bubble
        exp_pat = {vin, 4'b0000};
        obs     = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i < 10 && vin[i])
                drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            else
                drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            #3;
            obs[i] = out_valid;
        end
        n_vec++;
        if (obs !== exp_pat) begin
            n_err++;
            $display("FAIL stream_valid_pattern: got %b want %b", obs, exp_pat);
        end
        drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL stream_drain: %0d results outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] hold;
        logic [15:0] a4, b4;
        int          d0;
        bit          ok;
        d0 = n_deliv;
        a4 = 16'($urandom);
        b4 = 16'($urandom);
        hold = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 4) drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            else       drive(1'b1, a4, b4, 1'b0, 1'b1);
            out_ready = (i >= 4 && i <= 6) ? 1'b0 : 1'b1;
            #3;
            if (i == 4) begin
                hold = {S, COUT, OVF};
                n_vec++;
                if (out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_full: out_valid=%b want 1", out_valid);
                end
            end
            if (i >= 4 && i <= 6) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_in_ready slot %0d: got %b want 0", i, in_ready);
                end
            end
            if (i >= 5) begin
                n_vec++;
                if ({out_valid, S, COUT, OVF} !== {1'b1, hold}) begin
                    n_err++;
                    $display("FAIL bp_hold slot %0d: got ov=%b %h, want 1 %h", i, out_valid,
                             {S, COUT, OVF}, hold);
                end
            end
        end
        drain(ok);
        n_vec++;
        if (!ok || (n_deliv - d0) != 5) begin
            n_err++;
            $display("FAIL bp_deliver_once: delivered %0d outstanding %0d, want 5 and 0",
                     n_deliv - d0, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: out_valid=%b want 1", out_valid);
        end
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        n_vec++;
        if ({out_valid, S, COUT, OVF, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL midrst_async: got ov=%b S=%h C=%b O=%b ir=%b, want 0 0000 0 0 1",
                     out_valid, S, COUT, OVF, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            #3;
            n_vec++;
            if (c < 4) begin
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL midrst_early cyc %0d: out_valid=%b want 0", c, out_valid);
                end
            end else if ({out_valid, S, COUT, OVF} !== {1'b1, 16'h2345, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL midrst_result: got ov=%b S=%h C=%b O=%b, want 1 2345 0 0",
                         out_valid, S, COUT, OVF);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_carry_ripple();
        test_subtract();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL final_drain: %0d results outstanding, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
